// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI nibble receiver.
// Holds the FSM state encoding and the default frame length.
package spi_pkg;

  localparam int FRAME_BITS_DEF = 8;
  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // True when every bit above the operand nibble is zero.
  function automatic logic upper_clear(
    input logic [FRAME_BITS_DEF-1:0] f
  );
    return f[FRAME_BITS_DEF-1:NIBBLE_W] == '0;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer with registered edge strobes.
// Edges compare the last stage with one extra delayed copy.
module sync_edge_detect #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_in};
      prev_q <= sync_q[STAGES-1];
      rise   <= sync_q[STAGES-1] & ~prev_q;
      fall   <= ~sync_q[STAGES-1] & prev_q;
    end
  end

  assign level = sync_q[STAGES-1];

endmodule

// File: rtl/spi_nibble_rx.sv
// SPI mode-0 slave receiving one operand nibble per frame.
// Echoes the previously accepted nibble on miso, MSB first.
module spi_nibble_rx
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_BITS  = FRAME_BITS_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk_in,
  input  logic       mosi_in,
  input  logic       ss_n_in,
  output logic [3:0] data_out,
  output logic       data_valid_out,
  output logic       frame_err_out,
  output logic       miso_out
);

  localparam int CNT_W = $clog2(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic sclk_lvl;
  logic sclk_rise;
  logic sclk_fall;
  logic ss_lvl;
  logic ss_rise;
  logic ss_fall;
  logic mosi_lvl;

  logic [SYNC_STAGES-1:0] mosi_q;

  state_t state_q;
  state_t state_d;

  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      cnt_inc;
  logic [FRAME_BITS-1:0] frame_q;
  logic [FRAME_BITS-1:0] miso_q;

  logic start;
  logic shift_en;
  logic valid_d;
  logic err_d;
  logic frame_ok;
  logic unused_edges;

  sync_edge_detect #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b0)
  ) u_sclk (
    .clk   (clk),
    .rst   (rst),
    .d_in  (sclk_in),
    .level (sclk_lvl),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  sync_edge_detect #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b1)
  ) u_ss (
    .clk   (clk),
    .rst   (rst),
    .d_in  (ss_n_in),
    .level (ss_lvl),
    .rise  (ss_rise),
    .fall  (ss_fall)
  );

  // mosi only needs its level, aligned with the sclk chain
  always_ff @(posedge clk) begin
    if (rst) begin
      mosi_q <= '0;
    end else begin
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi_in};
    end
  end

  assign mosi_lvl     = mosi_q[SYNC_STAGES-1];
  assign unused_edges = ^{ss_rise, sclk_lvl};

  assign cnt_inc  = cnt_q + ONE;
  assign frame_ok = frame_q[FRAME_BITS-1:NIBBLE_W] == '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    start    = 1'b0;
    shift_en = 1'b0;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!ss_lvl && ss_fall) begin
          start   = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (ss_lvl) begin
          state_d = IDLE;
          err_d   = cnt_q != '0;
        end else if (sclk_rise && cnt_q != LAST) begin
          shift_en = 1'b1;
          if (cnt_inc == LAST) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        valid_d = frame_ok;
        err_d   = ~frame_ok;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q          <= '0;
      frame_q        <= '0;
      data_out       <= 4'h0;
      data_valid_out <= 1'b0;
      frame_err_out  <= 1'b0;
    end else begin
      data_valid_out <= valid_d;
      frame_err_out  <= err_d;
      if (start) begin
        cnt_q   <= '0;
        frame_q <= '0;
      end else if (shift_en) begin
        cnt_q   <= cnt_inc;
        frame_q <= {frame_q[FRAME_BITS-2:0], mosi_lvl};
      end
      if (valid_d) begin
        data_out <= frame_q[3:0];
      end
    end
  end

  // Echo register: loaded at select, advanced on each sclk fall
  always_ff @(posedge clk) begin
    if (rst) begin
      miso_q <= '0;
    end else if (ss_fall) begin
      miso_q <= {{(FRAME_BITS-NIBBLE_W){1'b0}}, data_out};
    end else if (sclk_fall) begin
      miso_q <= {miso_q[FRAME_BITS-2:0], 1'b0};
    end
  end

  assign miso_out = ~ss_lvl & miso_q[FRAME_BITS-1];

endmodule
